// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 source-scan scheduler.
package hc595_pkg;

    localparam int unsigned WORD_LEN = 24;
    localparam int unsigned EN_BIT   = 5;
    localparam int unsigned CH_W     = 5;

    localparam logic [WORD_LEN-1:0] BLANK_WORD = '0;

    // Word layout shifted into the 595 chain: source enable plus channel select
    typedef struct packed {
        logic [WORD_LEN-EN_BIT-2:0] pad;
        logic                       en;
        logic [EN_BIT-1:0]          ch;
    } hc595_word_t;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_SEARCH      = 4'd1,
        ST_ISSUE       = 4'd2,
        ST_ACK         = 4'd3,
        ST_DWELL       = 4'd4,
        ST_SAMPLE      = 4'd5,
        ST_BLANK_ISSUE = 4'd6,
        ST_BLANK_ACK   = 4'd7,
        ST_FRAME_END   = 4'd8
    } state_t;

    // Build the word that switches on the source for one channel
    function automatic logic [WORD_LEN-1:0] src_word(input logic [CH_W-1:0] ch);
        hc595_word_t w;
        w     = '0;
        w.en  = 1'b1;
        w.ch  = EN_BIT'(ch);
        return w;
    endfunction

endpackage

// File: rtl/hc595_cyc_timer.sv
// Down-counter shared between dwell timing and handshake timeout.
module hc595_cyc_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire_c
);

    logic [W-1:0] cnt;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire_c = (cnt == '0);

endmodule

// File: rtl/hc595_scan_sched.sv
// Scans enabled sources through a 595 driver: select, settle, sample, blank.
module hc595_scan_sched
    import hc595_pkg::*;
#(
    parameter int unsigned N_CH      = 32,
    parameter int unsigned DWELL_CYC = 5000,
    parameter int unsigned TMO_CYC   = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                cont,
    input  logic [N_CH-1:0]     ch_mask,
    output logic [WORD_LEN-1:0] hc595d_data,
    output logic [7:0]          hc595d_data_len,
    output logic                hc595d_wr_en,
    input  logic                hc595d_wr_finish,
    output logic                adc_trig,
    input  logic                adc_done,
    output logic [CH_W-1:0]     cur_ch,
    output logic                busy,
    output logic                frame_done,
    output logic                err_tmo
);

    localparam int unsigned TMR_MAX = (TMO_CYC > DWELL_CYC) ? TMO_CYC : DWELL_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_t              state;
    state_t              next_state;
    logic [CH_W-1:0]     ptr;
    logic [CH_W-1:0]     ptr_d;
    logic [N_CH-1:0]     mask_q;
    logic [N_CH-1:0]     mask_d;
    logic                stop_q;
    logic                stop_d;
    logic [WORD_LEN-1:0] data_d;
    logic                wr_en_d;
    logic                adc_trig_d;
    logic                frame_done_d;
    logic                busy_d;
    logic                err_d;

    logic                stop_pend;
    logic                last_ch;
    logic                is_wait;
    logic                wait_ok;
    logic                tmo_hit;
    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_expire;

    assign stop_pend = stop_q | stop;
    assign last_ch   = (ptr == CH_W'(N_CH - 1));
    assign is_wait   = (state == ST_ISSUE) || (state == ST_ACK) || (state == ST_SAMPLE) ||
                       (state == ST_BLANK_ISSUE) || (state == ST_BLANK_ACK);
    assign wait_ok   = (((state == ST_ISSUE) || (state == ST_BLANK_ISSUE)) && !hc595d_wr_finish) ||
                       (((state == ST_ACK) || (state == ST_BLANK_ACK)) && hc595d_wr_finish) ||
                       ((state == ST_SAMPLE) && adc_done);
    assign tmo_hit   = is_wait && !wait_ok && tmr_expire;

    assign hc595d_data_len = 8'(WORD_LEN);
    assign cur_ch          = ptr;

    hc595_cyc_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (state != ST_IDLE),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire_c (tmr_expire)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            mask_q       <= '0;
            stop_q       <= 1'b0;
            hc595d_data  <= BLANK_WORD;
            hc595d_wr_en <= 1'b0;
            adc_trig     <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            err_tmo      <= 1'b0;
        end else begin
            state        <= next_state;
            ptr          <= ptr_d;
            mask_q       <= mask_d;
            stop_q       <= stop_d;
            hc595d_data  <= data_d;
            hc595d_wr_en <= wr_en_d;
            adc_trig     <= adc_trig_d;
            frame_done   <= frame_done_d;
            busy         <= busy_d;
            err_tmo      <= err_d;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (start) next_state = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (stop_pend)        next_state = ST_IDLE;
                else if (mask_q[ptr]) next_state = ST_ISSUE;
                else if (last_ch)     next_state = ST_FRAME_END;
            end
            ST_ISSUE: begin
                if (wait_ok)      next_state = ST_ACK;
                else if (tmo_hit) next_state = ST_IDLE;
            end
            ST_ACK: begin
                if (wait_ok)      next_state = ST_DWELL;
                else if (tmo_hit) next_state = ST_IDLE;
            end
            ST_DWELL: begin
                if (tmr_expire) next_state = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (wait_ok)      next_state = ST_BLANK_ISSUE;
                else if (tmo_hit) next_state = ST_IDLE;
            end
            ST_BLANK_ISSUE: begin
                if (wait_ok)      next_state = ST_BLANK_ACK;
                else if (tmo_hit) next_state = ST_IDLE;
            end
            ST_BLANK_ACK: begin
                if (wait_ok) begin
                    if (stop_pend)    next_state = ST_IDLE;
                    else if (last_ch) next_state = ST_FRAME_END;
                    else              next_state = ST_SEARCH;
                end else if (tmo_hit) begin
                    next_state = ST_IDLE;
                end
            end
            ST_FRAME_END: begin
                if (cont && !stop_pend) next_state = ST_SEARCH;
                else                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Next values for datapath registers, outputs and timer control
    always_comb begin
        ptr_d        = ptr;
        mask_d       = mask_q;
        stop_d       = stop_q;
        data_d       = hc595d_data;
        wr_en_d      = (next_state == ST_ISSUE) || (next_state == ST_BLANK_ISSUE);
        adc_trig_d   = (next_state == ST_SAMPLE) && (state != ST_SAMPLE);
        frame_done_d = 1'b0;
        busy_d       = (next_state != ST_IDLE);
        err_d        = err_tmo;
        tmr_load     = (next_state != state);
        tmr_val      = (next_state == ST_DWELL) ? TMR_W'(DWELL_CYC - 1) : TMR_W'(TMO_CYC);

        if ((state != ST_IDLE) && stop) stop_d = 1'b1;
        if (next_state == ST_IDLE)      stop_d = 1'b0;

        if ((state == ST_IDLE) && start) begin
            mask_d = ch_mask;
            err_d  = 1'b0;
            ptr_d  = '0;
        end

        if (((state == ST_SEARCH) || (state == ST_BLANK_ACK)) && (next_state == ST_SEARCH)) begin
            ptr_d = ptr + CH_W'(1);
        end

        if (state == ST_FRAME_END) begin
            frame_done_d = !stop_pend;
            if (next_state == ST_SEARCH) begin
                mask_d = ch_mask;
                ptr_d  = '0;
            end
        end

        if ((next_state == ST_ISSUE) && (state != ST_ISSUE))             data_d = src_word(ptr);
        if ((next_state == ST_BLANK_ISSUE) && (state != ST_BLANK_ISSUE)) data_d = BLANK_WORD;

        if (tmo_hit) err_d = 1'b1;
    end

endmodule

// File: tb/tb_hc595_scan_sched.sv
// Directed bench for hc595_scan_sched with driver and ADC behavioural models.
module tb_hc595_scan_sched;

    localparam int unsigned N_CH  = 32;
    localparam int unsigned DWELL = 16;
    localparam int unsigned TMO   = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        cont;
    logic [31:0] ch_mask;
    logic [23:0] hc595d_data;
    logic [7:0]  hc595d_data_len;
    logic        hc595d_wr_en;
    logic        hc595d_wr_finish;
    logic        adc_trig;
    logic        adc_done;
    logic [4:0]  cur_ch;
    logic        busy;
    logic        frame_done;
    logic        err_tmo;

    hc595_scan_sched #(
        .N_CH      (N_CH),
        .DWELL_CYC (DWELL),
        .TMO_CYC   (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .stop             (stop),
        .cont             (cont),
        .ch_mask          (ch_mask),
        .hc595d_data      (hc595d_data),
        .hc595d_data_len  (hc595d_data_len),
        .hc595d_wr_en     (hc595d_wr_en),
        .hc595d_wr_finish (hc595d_wr_finish),
        .adc_trig         (adc_trig),
        .adc_done         (adc_done),
        .cur_ch           (cur_ch),
        .busy             (busy),
        .frame_done       (frame_done),
        .err_tmo          (err_tmo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state and observation logs
    logic [23:0] words[$];
    int          gaps[$];
    int          trigs  = 0;
    int          frames = 0;
    int          raises = 0;
    int          raise_cyc = 0;
    int          drv_phase = 0;
    int          drv_cnt   = 0;
    int          adc_cnt   = 0;
    logic        drv_stuck = 1'b0;

    typedef struct {
        logic [31:0] mask;
        int          exp_writes;
        int          exp_trigs;
        int          exp_frames;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic clear_logs();
        words.delete();
        gaps.delete();
        trigs  = 0;
        frames = 0;
        raises = 0;
    endtask

    // Driver (finish drops 3 cycles after wr_en, returns 4 later) and ADC model
    initial begin
        hc595d_wr_finish = 1'b1;
        adc_done         = 1'b0;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            if (rst) begin
                drv_phase        = 0;
                drv_cnt          = 0;
                adc_cnt          = 0;
                hc595d_wr_finish = 1'b1;
            end else begin
                case (drv_phase)
                    0: if (hc595d_wr_en) begin
                        words.push_back(hc595d_data);
                        drv_phase = 1;
                        drv_cnt   = 3;
                    end
                    1: if (drv_stuck) begin
                        if (!hc595d_wr_en) drv_phase = 0;
                    end else begin
                        drv_cnt--;
                        if (drv_cnt == 0) begin
                            hc595d_wr_finish = 1'b0;
                            drv_phase        = 2;
                            drv_cnt          = 4;
                        end
                    end
                    2: begin
                        drv_cnt--;
                        if (drv_cnt == 0) begin
                            hc595d_wr_finish = 1'b1;
                            raise_cyc        = cyc;
                            raises++;
                            drv_phase        = 3;
                        end
                    end
                    default: if (!hc595d_wr_en) drv_phase = 0;
                endcase
                if (adc_cnt > 0) begin
                    adc_cnt--;
                    if (adc_cnt == 0) adc_done = 1'b1;
                end
                if (adc_trig) begin
                    trigs++;
                    adc_cnt = 3;
                    gaps.push_back(cyc - raise_cyc - 1);
                end
                if (frame_done) frames++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] exp_words[$];
        logic [31:0] m;
        int          k;
        int          n;

        vecs[0] = '{32'h0000_0005, 4, 2, 1};
        vecs[1] = '{32'h0000_0000, 0, 0, 1};
        vecs[2] = '{32'h8000_0000, 2, 1, 1};
        vecs[3] = '{32'h8000_0001, 4, 2, 1};
        vecs[4] = '{32'h0000_0012, 4, 2, 1};

        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; ch_mask = '0;
        tick(3);
        check("rst_data",     32'(hc595d_data),     32'h0);
        check("rst_wr_en",    32'(hc595d_wr_en),    32'h0);
        check("rst_trig",     32'(adc_trig),        32'h0);
        check("rst_busy",     32'(busy),            32'h0);
        check("rst_frame",    32'(frame_done),      32'h0);
        check("rst_err",      32'(err_tmo),         32'h0);
        check("rst_cur_ch",   32'(cur_ch),          32'h0);
        check("data_len",     32'(hc595d_data_len), 32'd24);
        rst = 1'b0;
        tick(2);

        // Single-frame scans over a table of masks
        for (int v = 0; v < 5; v++) begin
            clear_logs();
            exp_words.delete();
            m = vecs[v].mask;
            for (int ch = 0; ch < 32; ch++) begin
                if (m[ch]) begin
                    exp_words.push_back(24'h20 | 24'(ch));
                    exp_words.push_back(24'h0);
                end
            end
            ch_mask = vecs[v].mask;
            start = 1'b1;
            tick(1);
            start = 1'b0;
            tick(10);
            start = 1'b1;
            tick(2);
            start = 1'b0;
            wait_idle("vec_idle", 2000);
            tick(3);
            check("vec_writes", 32'(words.size()), 32'(vecs[v].exp_writes));
            check("vec_trigs",  32'(trigs),        32'(vecs[v].exp_trigs));
            check("vec_frames", 32'(frames),       32'(vecs[v].exp_frames));
            check("vec_err",    32'(err_tmo),      32'h0);
            check("vec_wr_en",  32'(hc595d_wr_en), 32'h0);
            for (int i = 0; i < exp_words.size(); i++) begin
                if (i < words.size()) check("vec_word", 32'(words[i]), 32'(exp_words[i]));
            end
            for (int i = 0; i < gaps.size(); i++) check("dwell_gap", 32'(gaps[i]), 32'(DWELL));
        end

        // Empty mask: frame_done N_CH+1 edges after the start-sampling edge
        clear_logs();
        ch_mask = '0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n = 0;
        while (!frame_done && n < 60) begin
            tick(1);
            n++;
        end
        check("empty_frame_delay", 32'(n), 32'(N_CH + 1));
        check("empty_busy",        32'(busy), 32'h0);
        tick(2);

        // Stop during the dwell of channel 0
        clear_logs();
        ch_mask = 32'h0000_00FF;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k = 0;
        while (raises < 1 && k < 200) begin
            tick(1);
            k++;
        end
        check("stop_reach_dwell", 32'(raises), 32'd1);
        check("stop_cur_ch",      32'(cur_ch), 32'd0);
        tick(3);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_idle("stop_idle", 500);
        tick(3);
        check("stop_trigs",  32'(trigs),        32'd1);
        check("stop_writes", 32'(words.size()), 32'd2);
        if (words.size() == 2) begin
            check("stop_word0", 32'(words[0]), 32'h20);
            check("stop_word1", 32'(words[1]), 32'h0);
        end
        check("stop_frames", 32'(frames), 32'd0);

        // Driver never drops finish: timeout path
        clear_logs();
        drv_stuck = 1'b1;
        ch_mask = 32'h0000_0001;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k = 0;
        while (!hc595d_wr_en && k < 50) begin
            tick(1);
            k++;
        end
        check("tmo_wr_en_seen", 32'(hc595d_wr_en), 32'h1);
        n = 0;
        while (busy && n < 300) begin
            tick(1);
            n++;
        end
        check("tmo_delay", 32'(n),            32'(TMO + 1));
        check("tmo_err",   32'(err_tmo),      32'h1);
        check("tmo_wr_en", 32'(hc595d_wr_en), 32'h0);
        check("tmo_busy",  32'(busy),         32'h0);
        drv_stuck = 1'b0;
        tick(3);
        ch_mask = '0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("tmo_err_cleared", 32'(err_tmo), 32'h0);
        wait_idle("tmo_restart_idle", 100);
        tick(2);

        // Continuous mode, then a graceful stop
        clear_logs();
        ch_mask = 32'h0000_0002;
        cont = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k = 0;
        while (frames < 2 && k < 600) begin
            tick(1);
            k++;
        end
        check("cont_two_frames", 32'(frames >= 2), 32'h1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        cont = 1'b0;
        wait_idle("cont_idle", 500);
        tick(3);
        check("cont_even_writes", 32'(words.size() % 2), 32'h0);
        if (words.size() > 0) check("cont_last_blank", 32'(words[words.size()-1]), 32'h0);
        check("cont_src_word", (words.size() > 0) ? 32'(words[0]) : 32'hFFFF_FFFF, 32'h21);

        // Reset while waiting in ACK
        clear_logs();
        ch_mask = 32'h0000_0004;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k = 0;
        while (!(words.size() == 1 && !hc595d_wr_en) && k < 200) begin
            tick(1);
            k++;
        end
        check("ack_reached", 32'(words.size()), 32'd1);
        check("ack_cur_ch",  32'(cur_ch),       32'd2);
        check("ack_busy",    32'(busy),         32'h1);
        check("ack_data",    32'(hc595d_data),  32'h22);
        rst = 1'b1;
        tick(1);
        check("ackrst_data",   32'(hc595d_data),  32'h0);
        check("ackrst_wr_en",  32'(hc595d_wr_en), 32'h0);
        check("ackrst_trig",   32'(adc_trig),     32'h0);
        check("ackrst_busy",   32'(busy),         32'h0);
        check("ackrst_frame",  32'(frame_done),   32'h0);
        check("ackrst_err",    32'(err_tmo),      32'h0);
        check("ackrst_cur_ch", 32'(cur_ch),       32'h0);
        rst = 1'b0;
        tick(3);
        check("ackrst_stays_idle", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
